// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: assembles symbolic MIPS commands into 32-bit words and writes them to imem.
// AUTO_DELAY_SLOT_EN: when defined, a NOP delay slot is written after every branch/jump word.
module mips_instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [5:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  input  logic              imem_ready,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);
  typedef enum logic [1:0] {
    IDLE,
`ifdef AUTO_DELAY_SLOT_EN
    SLOT,
`endif
    WRITE
  } state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] word;
  logic legal, accept;
  logic [25:0] rr, sh, it, iz, lu;
  assign rr = {6'd0, cmd_rs, cmd_rt, cmd_rd, 5'd0};
  assign sh = {6'd0, 5'd0, cmd_rt, cmd_rd, cmd_shamt};
  assign it = {cmd_rs, cmd_rt, cmd_imm};
  assign iz = {cmd_rs, 5'd0, cmd_imm};
  assign lu = {5'd0, cmd_rt, cmd_imm};
  assign cmd_ready = (state == IDLE) & ~load_base & ~error;
  assign accept = cmd_valid & cmd_ready;
  assign busy = state != IDLE;
  assign imem_we = state != IDLE;
  always_comb begin
    word = '0;
    legal = 1'b1;
    case (cmd_op)
      6'd0:  word = {rr, 6'h20};
      6'd1:  word = {rr, 6'h21};
      6'd2:  word = {rr, 6'h22};
      6'd3:  word = {rr, 6'h23};
      6'd4:  word = {rr, 6'h24};
      6'd5:  word = {rr, 6'h25};
      6'd6:  word = {rr, 6'h2a};
      6'd7:  word = {rr, 6'h2b};
      6'd8:  word = {rr, 6'h04};
      6'd9:  word = {rr, 6'h06};
      6'd10: word = {rr, 6'h0b};
      6'd11: word = {rr, 6'h0a};
      6'd12: word = {sh, 6'h00};
      6'd13: word = {sh, 6'h02};
      6'd14: word = {6'h00, cmd_rs, 15'd0, 6'h08};
      6'd15: word = {6'h08, it};
      6'd16: word = {6'h09, it};
      6'd17: word = {6'h0a, it};
      6'd18: word = {6'h0b, it};
      6'd19: word = {6'h0c, it};
      6'd20: word = {6'h0d, it};
      6'd21: word = {6'h0f, lu};
      6'd22: word = {6'h23, it};
      6'd23: word = {6'h20, it};
      6'd24: word = {6'h24, it};
      6'd25: word = {6'h2b, it};
      6'd26: word = {6'h28, it};
      6'd27: word = {6'h04, it};
      6'd28: word = {6'h05, it};
      6'd29: word = {6'h07, iz};
      6'd30: word = {6'h06, iz};
      6'd31: word = {6'h01, cmd_rs, 5'h00, cmd_imm};
      6'd32: word = {6'h01, cmd_rs, 5'h01, cmd_imm};
      6'd33: word = {6'h01, cmd_rs, 5'h10, cmd_imm};
      6'd34: word = {6'h01, cmd_rs, 5'h11, cmd_imm};
      6'd35: word = {6'h02, cmd_target};
      6'd36: word = {6'h03, cmd_target};
      default: legal = 1'b0;
    endcase
  end
`ifdef AUTO_DELAY_SLOT_EN
  logic br;
  logic br_cmd;
  assign br_cmd = (cmd_op == 6'd14) | (cmd_op >= 6'd27 & cmd_op <= 6'd36);
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = accept & legal ? WRITE : IDLE;
`ifdef AUTO_DELAY_SLOT_EN
      WRITE: state_n = imem_ready ? (br ? SLOT : IDLE) : WRITE;
      SLOT:  state_n = imem_ready ? IDLE : SLOT;
`else
      WRITE: state_n = imem_ready ? IDLE : WRITE;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      imem_addr <= '0;
      imem_data <= '0;
      error <= 1'b0;
      words_written <= '0;
`ifdef AUTO_DELAY_SLOT_EN
      br <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && load_base) begin
        ptr <= base_addr;
        error <= 1'b0;
        words_written <= '0;
      end else if (accept) begin
        if (legal) begin
          imem_data <= word;
          imem_addr <= ptr;
`ifdef AUTO_DELAY_SLOT_EN
          br <= br_cmd;
`endif
        end else error <= 1'b1;
      end
      if (state != IDLE && imem_ready) begin
        ptr <= ptr + 1'b1;
        words_written <= &words_written ? words_written : words_written + 1'b1;
`ifdef AUTO_DELAY_SLOT_EN
        if (state == WRITE && br) begin
          imem_data <= '0;
          imem_addr <= ptr + 1'b1;
        end
`endif
      end
    end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: randomized scoreboard bench for mips_instr_encoder against a table-driven encoding model.
module tb_mips_instr_encoder;
  localparam int AW = 10;
`ifdef AUTO_DELAY_SLOT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, load_base = 1'b0, cmd_valid = 1'b0, imem_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [5:0] cmd_op = '0;
  logic [4:0] cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
  logic [15:0] cmd_imm = '0;
  logic [25:0] cmd_target = '0;
  logic cmd_ready, imem_we, busy, error;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_data;
  logic [AW:0] words_written;
  int checks = 0, fails = 0;
  int rdy_mode = 0;
  logic [AW+31:0] sb[$];
  int m_ptr = 0, m_words = 0;
  bit m_err = 0;
  int fn_t[15] = '{32, 33, 34, 35, 36, 37, 42, 43, 4, 6, 11, 10, 0, 2, 8};
  int oc_t[22] = '{8, 9, 10, 11, 12, 13, 15, 35, 32, 36, 43, 40, 4, 5, 7, 6, 1, 1, 1, 1, 2, 3};
  int ri_t[4] = '{0, 1, 16, 17};

  mips_instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .load_base(load_base), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_shamt(cmd_shamt),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_data(imem_data), .imem_ready(imem_ready),
    .busy(busy), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int op, input logic [4:0] rs, rt, rd, sa,
                                           input logic [15:0] imm, input logic [25:0] tg);
    logic [31:0] a, b, d, s, i, t;
    a = {27'd0, rs}; b = {27'd0, rt}; d = {27'd0, rd}; s = {27'd0, sa};
    i = {16'd0, imm}; t = {6'd0, tg};
    if (op <= 11) return (a << 21) + (b << 16) + (d << 11) + 32'(fn_t[op]);
    if (op <= 13) return (b << 16) + (d << 11) + (s << 6) + 32'(fn_t[op]);
    if (op == 14) return (a << 21) + 32'(fn_t[op]);
    if (op == 21) return (32'(oc_t[op-15]) << 26) + (b << 16) + i;
    if (op == 29 || op == 30) return (32'(oc_t[op-15]) << 26) + (a << 21) + i;
    if (op >= 31 && op <= 34) return (32'(oc_t[op-15]) << 26) + (a << 21) + (32'(ri_t[op-31]) << 16) + i;
    if (op >= 35) return (32'(oc_t[op-15]) << 26) + t;
    return (32'(oc_t[op-15]) << 26) + (a << 21) + (b << 16) + i;
  endfunction

  function automatic void model_write(input logic [31:0] w);
    sb.push_back({AW'(m_ptr), w});
    m_ptr = (m_ptr + 1) % (1 << AW);
    if (m_words < (1 << (AW + 1)) - 1) m_words++;
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    imem_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: pops the scoreboard on every completed write and checks stall stability.
  initial begin
    logic held;
    logic [AW-1:0] ha;
    logic [31:0] hd;
    logic [AW+31:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) held = 1'b0;
      else if (imem_we) begin
        if (held) begin
          check("stall_addr", 64'(imem_addr), 64'(ha));
          check("stall_data", 64'(imem_data), 64'(hd));
        end
        if (imem_ready) begin
          if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", imem_addr, imem_data);
          end else begin
            e = sb.pop_front();
            check("wr_addr", 64'(imem_addr), 64'(e[AW+31:32]));
            check("wr_data", 64'(imem_data), 64'(e[31:0]));
          end
          held = 1'b0;
        end else begin
          held = 1'b1; ha = imem_addr; hd = imem_data;
        end
      end else held = 1'b0;
    end
  end

  task automatic issue(input int op, input logic [4:0] rs, rt, rd, sa,
                       input logic [15:0] imm, input logic [25:0] tg);
    int n;
    cmd_op = 6'(op); cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_shamt = sa;
    cmd_imm = imm; cmd_target = tg; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: cmd_ready %0b, expected 1 within 40 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    if (op <= 36) begin
      model_write(ref_word(op, rs, rt, rd, sa, imm, tg));
      if (EN && (op == 14 || (op >= 27 && op <= 36))) model_write(32'd0);
    end else m_err = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    if (op <= 36) begin
      check("lat_we", 64'(imem_we), 64'd1);
      check("lat_busy", 64'(busy), 64'd1);
      check("lat_ready", 64'(cmd_ready), 64'd0);
    end else begin
      check("illegal_we", 64'(imem_we), 64'd0);
      check("illegal_err", 64'(error), 64'd1);
      check("illegal_ready", 64'(cmd_ready), 64'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("drain_idle", 64'(busy), 64'd0);
    check("words", 64'(words_written), 64'(m_words));
    check("err_state", 64'(error), 64'(m_err));
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic load(input logic [AW-1:0] b);
    load_base = 1'b1; base_addr = b;
    @(posedge clk);
    #1 load_base = 1'b0;
    m_ptr = int'(b); m_words = 0; m_err = 1'b0;
    @(negedge clk);
    check("load_words", 64'(words_written), 64'd0);
    check("load_err", 64'(error), 64'd0);
    check("load_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    @(negedge clk);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_data", 64'(imem_data), 64'd0);
    check("rst_err", 64'(error), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    issue(1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    drain();
    load(10'h3FF);
    issue(15, 5'd0, 5'd2, 5'd0, 5'd0, 16'd5, 26'd0);
    issue(21, 5'd0, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0);
    drain();
    issue(27, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0);
    drain();
    rdy_mode = 2;
    issue(35, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    load_base = 1'b1; base_addr = 10'h055;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", 64'(cmd_ready), 64'd0);
      check("stall_we", 64'(imem_we), 64'd1);
    end
    load_base = 1'b0;
    rdy_mode = 0;
    drain();
    issue(40, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    cmd_op = 6'd1; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("err_blocks", 64'(cmd_ready), 64'd0);
      check("err_idle", 64'(busy), 64'd0);
    end
    cmd_valid = 1'b0;
    drain();
    load(10'h010);
    issue(12, 5'd7, 5'd5, 5'd6, 5'd3, 16'd0, 26'd0);
    drain();
    load_base = 1'b1; base_addr = 10'h100; cmd_valid = 1'b1; cmd_op = 6'd1;
    #1 check("load_wins", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 begin load_base = 1'b0; cmd_valid = 1'b0; end
    m_ptr = 'h100; m_words = 0; m_err = 1'b0;
    @(negedge clk);
    check("load_wins_idle", 64'(busy), 64'd0);
    issue(0, 5'd9, 5'd10, 5'd11, 5'd0, 16'd0, 26'd0);
    drain();
    load(10'h3FE);
    rdy_mode = 1;
    for (int k = 0; k < 150; k++) begin
      op = ($urandom_range(0, 19) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 36));
      if ($urandom_range(0, 14) == 0) begin
        drain();
        load(AW'($urandom));
      end
      issue(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      if (op > 36) begin
        drain();
        load(AW'($urandom));
      end
    end
    rdy_mode = 0;
    drain();
    rdy_mode = 2;
    issue(1, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    #1 rst = 1'b1;
    #1 begin
      check("arst_we", 64'(imem_we), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
    end
    sb.delete();
    m_ptr = 0; m_words = 0; m_err = 1'b0;
    @(posedge clk);
    #1 begin rst = 1'b0; rdy_mode = 0; end
    @(negedge clk);
    issue(5, 5'd3, 5'd4, 5'd5, 5'd0, 16'd0, 26'd0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Encoder counterpart to the MIPS decode stage. Accepts symbolic instruction commands (operation, register numbers, immediate, target) over a valid/ready handshake. Assembles each command into a 32-bit MIPS word using the field layout and opcode/funct values of mips_defines.v, then writes it to instruction memory at an auto-incrementing word address. Used by the boot-loader and self-test sequencer to place program images without a host assembler.

Parameters:
ADDR_W, 10, instruction-memory word-address width; address wraps modulo 2^ADDR_W.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
load_base  in  1  load write pointer (accepted in IDLE only)
base_addr  in  ADDR_W  new word address
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  6  operation code (enumeration below)
cmd_rs, cmd_rt, cmd_rd, cmd_shamt  in  5 each  register fields / shift amount
cmd_imm  in  16  immediate / branch offset
cmd_target  in  26  jump target field
imem_we  out  1  write strobe, held until imem_ready
imem_addr  out  ADDR_W  word address
imem_data  out  32  encoded instruction
imem_ready  in  1  memory accepts write this cycle
busy  out  1  state != IDLE
error  out  1  sticky illegal-op flag
words_written  out  ADDR_W+1  words written since last load_base; saturates at all-ones

Behaviour:
- Reset: state=IDLE, pointer=0, imem_we=0, imem_addr=0, imem_data=0, error=0, words_written=0, busy=0. cmd_ready reflects IDLE (1).
- cmd_op enumeration: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 SLT, 7 SLTU, 8 SLLV, 9 SRLV, 10 MOVN, 11 MOVZ, 12 SLL, 13 SRL, 14 JR, 15 ADDI, 16 ADDIU, 17 SLTI, 18 SLTIU, 19 ANDI, 20 ORI, 21 LUI, 22 LW, 23 LB, 24 LBU, 25 SW, 26 SB, 27 BEQ, 28 BNE, 29 BGTZ, 30 BLEZ, 31 BLTZ, 32 BGEZ, 33 BLTZAL, 34 BGEZAL, 35 J, 36 JAL. Codes 37-63 are illegal.
- Encoding; unused fields are forced to 0:
  - ops 0-11: {SPECIAL, rs, rt, rd, 00000, funct}.
  - 12-13: {SPECIAL, 00000, rt, rd, shamt, funct}.
  - 14: {SPECIAL, rs, 15'b0, JR}.
  - 15-20, 22-28: {op, rs, rt, imm}.
  - 21: {LUI, 00000, rt, imm}.
  - 29-30: {op, rs, 00000, imm}.
  - 31-34: {000001, rs, regimm code, imm}.
  - 35-36: {op, target}.
- cmd_ready = (state==IDLE) & ~load_base & ~error.
- FSM:
  - IDLE:
    - load_base → pointer=base_addr, error=0, words_written=0; stay IDLE.
    - Accepted legal cmd → register encoded word into imem_data, imem_addr=pointer; go WRITE.
    - Accepted illegal cmd → error=1; stay IDLE; nothing written.
  - WRITE: imem_we=1. On imem_ready: pointer++, words_written++. If AUTO_DELAY_SLOT_EN and op is branch/jump (14, 27-36), go SLOT; else go IDLE.
  - SLOT: imem_data=0x00000000, imem_addr=pointer, imem_we=1. On imem_ready: pointer++, words_written++; go IDLE.
- imem_addr and imem_data must remain stable while imem_we=1 and imem_ready=0.
- Latency: cmd accepted at cycle N → imem_we=1 at N+1. With imem_ready tied high, cmd_ready returns at N+2, giving 1 word per 2 cycles.
- Boundaries:
  - Pointer at 2^ADDR_W-1 wraps to 0 after the write.
  - load_base outside IDLE is ignored.
  - load_base and cmd_valid together in IDLE: load wins and the cmd is not accepted.
  - While error=1 no commands are accepted; only load_base or rst clears it.
  - rst mid-WRITE/SLOT drops imem_we immediately (asynchronous) and the pending write is lost.

Optional Feature:
AUTO_DELAY_SLOT_EN
- Defined: after each branch/jump word, the encoder writes a NOP (0x00000000) to the next address through the SLOT state before returning to IDLE.
- Undefined: the SLOT state is absent; branch/jump words are written like any other word, and delay-slot filling is the command source's responsibility.

Test Plan:
- Reset, then ADDU rs=1 rt=2 rd=3 → imem_we at cycle 1, addr 0, data 0x00221821; words_written=1.
- load_base 0x3FF, then ADDI rs=0 rt=2 imm=5, then LUI rt=4 imm=0x1234 → 0x20020005 at 0x3FF, 0x3C041234 at 0x000 (wrap).
- BEQ rs=1 rt=2 imm=0xFFFF with EN defined → 0x1022FFFF at addr k, 0x00000000 at k+1, words_written+=2. Without EN → only one write.
- J target=0x10 with imem_ready low for 3 cycles → data 0x08000010 and addr held stable with we=1 across stall; cmd_ready=0 until completion.
- cmd_op=40 → no write, error=1, cmd_ready=0; load_base → error=0, cmd_ready=1.
- SLL rt=5 rd=6 shamt=3 with nonzero cmd_rs=7 → 0x000530C0 (rs field zeroed).
